// File: rtl/prv_trap_sequencer_pkg.sv
// Shared privilege definitions for the machine-mode trap/return sequencer:
// FSM state type, mcause codes and bit positions inside exc_vec / irq_vec.
package prv_trap_sequencer_pkg;

    localparam int CAUSE_W = 5;
    localparam int EXC_W   = 9;
    localparam int IRQ_W   = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRAP_WAIT = 3'd1,
        ST_TRAP_GO   = 3'd2,
        ST_RET_WAIT  = 3'd3,
        ST_RET_GO    = 3'd4
    } trap_state_t;

    // Exception cause codes (mcause[31] = 0)
    localparam logic [CAUSE_W-1:0] CAUSE_MAL_INSN   = 5'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_FAULT_INSN = 5'd1;
    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL    = 5'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_BREAKPOINT = 5'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_MAL_L      = 5'd4;
    localparam logic [CAUSE_W-1:0] CAUSE_FAULT_L    = 5'd5;
    localparam logic [CAUSE_W-1:0] CAUSE_MAL_S      = 5'd6;
    localparam logic [CAUSE_W-1:0] CAUSE_FAULT_S    = 5'd7;
    localparam logic [CAUSE_W-1:0] CAUSE_ENV_M      = 5'd11;

    // Interrupt cause codes (mcause[31] = 1)
    localparam logic [CAUSE_W-1:0] CAUSE_IRQ_SOFT   = 5'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_IRQ_TIMER  = 5'd7;
    localparam logic [CAUSE_W-1:0] CAUSE_IRQ_EXT    = 5'd11;

    // Bit positions in exc_vec; lowest index is highest priority
    localparam int EXC_IDX_FAULT_INSN = 0;
    localparam int EXC_IDX_MAL_INSN   = 1;
    localparam int EXC_IDX_ILLEGAL    = 2;
    localparam int EXC_IDX_BREAKPOINT = 3;
    localparam int EXC_IDX_ENV_M      = 4;
    localparam int EXC_IDX_MAL_S      = 5;
    localparam int EXC_IDX_MAL_L      = 6;
    localparam int EXC_IDX_FAULT_S    = 7;
    localparam int EXC_IDX_FAULT_L    = 8;

    // Bit positions in irq_vec / mie_en
    localparam int EXC_IDX_SOFT_INT   = 0;
    localparam int EXC_IDX_TIMER_INT  = 1;
    localparam int EXC_IDX_EXT_INT    = 2;

    // Address-related exceptions report the faulting address in mtval
    function automatic logic cause_has_tval(input logic [CAUSE_W-1:0] code);
        case (code)
            CAUSE_MAL_INSN, CAUSE_FAULT_INSN,
            CAUSE_MAL_L, CAUSE_FAULT_L,
            CAUSE_MAL_S, CAUSE_FAULT_S: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/prv_cause_encoder.sv
// Combinational trap-cause priority encoder: synchronous exceptions first,
// then globally and individually enabled interrupts.
module prv_cause_encoder
    import prv_trap_sequencer_pkg::*;
(
    input  logic [EXC_W-1:0]   exc_vec,
    input  logic [IRQ_W-1:0]   irq_vec,
    input  logic [IRQ_W-1:0]   mie_en,
    input  logic               mstatus_mie,
    output logic               valid,
    output logic               is_int,
    output logic [CAUSE_W-1:0] code
);

    logic [IRQ_W-1:0] pending;

    always_comb begin
        valid   = 1'b0;
        is_int  = 1'b0;
        code    = '0;
        pending = irq_vec & mie_en;

        if (exc_vec != '0) begin
            valid = 1'b1;
            if      (exc_vec[EXC_IDX_FAULT_INSN]) code = CAUSE_FAULT_INSN;
            else if (exc_vec[EXC_IDX_MAL_INSN])   code = CAUSE_MAL_INSN;
            else if (exc_vec[EXC_IDX_ILLEGAL])    code = CAUSE_ILLEGAL;
            else if (exc_vec[EXC_IDX_BREAKPOINT]) code = CAUSE_BREAKPOINT;
            else if (exc_vec[EXC_IDX_ENV_M])      code = CAUSE_ENV_M;
            else if (exc_vec[EXC_IDX_MAL_S])      code = CAUSE_MAL_S;
            else if (exc_vec[EXC_IDX_MAL_L])      code = CAUSE_MAL_L;
            else if (exc_vec[EXC_IDX_FAULT_S])    code = CAUSE_FAULT_S;
            else                                  code = CAUSE_FAULT_L;
        end else if (mstatus_mie && (pending != '0)) begin
            valid  = 1'b1;
            is_int = 1'b1;
            if      (pending[EXC_IDX_EXT_INT])    code = CAUSE_IRQ_EXT;
            else if (pending[EXC_IDX_SOFT_INT])   code = CAUSE_IRQ_SOFT;
            else                                  code = CAUSE_IRQ_TIMER;
        end
    end

endmodule

// File: rtl/prv_trap_sequencer.sv
// Machine-mode trap/mret sequencer: latch cause, wait for pipeline drain,
// then pulse the CSR update and PC redirect. Define PRV_VECTORED_INT_EN for
// vectored interrupt targets when mtvec[1:0] == 2'b01.
module prv_trap_sequencer
    import prv_trap_sequencer_pkg::*;
#(
    parameter int RV_XLEN = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [EXC_W-1:0]   exc_vec,
    input  logic               ret,
    input  logic               pipe_clear,
    input  logic [RV_XLEN-1:0] epc,
    input  logic [RV_XLEN-1:0] badaddr,
    input  logic [IRQ_W-1:0]   irq_vec,
    input  logic               mstatus_mie,
    input  logic [IRQ_W-1:0]   mie_en,
    input  logic [RV_XLEN-1:0] mtvec,
    input  logic [RV_XLEN-1:0] mepc_r,
    output logic               insert_pc,
    output logic [RV_XLEN-1:0] priv_pc,
    output logic               intr,
    output logic               trap_we,
    output logic               mret_we,
    output logic [RV_XLEN-1:0] mepc_w,
    output logic [RV_XLEN-1:0] mcause_w,
    output logic [RV_XLEN-1:0] mtval_w,
    output logic               busy
);

    trap_state_t        state_q,  state_d;
    logic               int_q,    int_d;
    logic [CAUSE_W-1:0] code_q,   code_d;
    logic [RV_XLEN-1:0] epc_q,    epc_d;
    logic [RV_XLEN-1:0] tval_q,   tval_d;

    logic               enc_valid;
    logic               enc_is_int;
    logic [CAUSE_W-1:0] enc_code;
    logic [RV_XLEN-1:0] trap_base;
    logic [RV_XLEN-1:0] trap_target;

    prv_cause_encoder u_cause_encoder (
        .exc_vec     (exc_vec),
        .irq_vec     (irq_vec),
        .mie_en      (mie_en),
        .mstatus_mie (mstatus_mie),
        .valid       (enc_valid),
        .is_int      (enc_is_int),
        .code        (enc_code)
    );

    assign trap_base = mtvec & ~RV_XLEN'(3);

`ifdef PRV_VECTORED_INT_EN
    always_comb begin
        trap_target = trap_base;
        if (int_q && (mtvec[1:0] == 2'b01)) begin
            trap_target = trap_base + RV_XLEN'({code_q, 2'b00});
        end
    end
`else
    assign trap_target = trap_base;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            int_q   <= 1'b0;
            code_q  <= '0;
            epc_q   <= '0;
            tval_q  <= '0;
        end else begin
            state_q <= state_d;
            int_q   <= int_d;
            code_q  <= code_d;
            epc_q   <= epc_d;
            tval_q  <= tval_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        int_d     = int_q;
        code_d    = code_q;
        epc_d     = epc_q;
        tval_d    = tval_q;

        insert_pc = 1'b0;
        priv_pc   = '0;
        intr      = 1'b0;
        trap_we   = 1'b0;
        mret_we   = 1'b0;
        mepc_w    = '0;
        mcause_w  = '0;
        mtval_w   = '0;
        busy      = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                // Exceptions/interrupts win over a simultaneous mret
                if (enc_valid) begin
                    state_d = ST_TRAP_WAIT;
                    int_d   = enc_is_int;
                    code_d  = enc_code;
                    epc_d   = epc;
                    tval_d  = (!enc_is_int && cause_has_tval(enc_code)) ? badaddr : '0;
                end else if (ret) begin
                    state_d = ST_RET_WAIT;
                end
            end
            ST_TRAP_WAIT: begin
                intr = int_q;
                if (pipe_clear) state_d = ST_TRAP_GO;
            end
            ST_TRAP_GO: begin
                intr      = int_q;
                trap_we   = 1'b1;
                insert_pc = 1'b1;
                priv_pc   = trap_target;
                mepc_w    = epc_q;
                mcause_w  = {int_q, {(RV_XLEN-1-CAUSE_W){1'b0}}, code_q};
                mtval_w   = tval_q;
                state_d   = ST_IDLE;
            end
            ST_RET_WAIT: begin
                if (pipe_clear) state_d = ST_RET_GO;
            end
            ST_RET_GO: begin
                mret_we   = 1'b1;
                insert_pc = 1'b1;
                priv_pc   = mepc_r;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_prv_trap_sequencer.sv
// Self-checking bench for prv_trap_sequencer: directed cases plus randomized
// transactions checked against a priority-table reference model.
module tb_prv_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  exc_vec;
    logic        ret;
    logic        pipe_clear;
    logic [31:0] epc;
    logic [31:0] badaddr;
    logic [2:0]  irq_vec;
    logic        mstatus_mie;
    logic [2:0]  mie_en;
    logic [31:0] mtvec;
    logic [31:0] mepc_r;
    logic        insert_pc;
    logic [31:0] priv_pc;
    logic        intr;
    logic        trap_we;
    logic        mret_we;
    logic [31:0] mepc_w;
    logic [31:0] mcause_w;
    logic [31:0] mtval_w;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Reference tables, indexed by exc_vec bit (bit 0 = highest priority)
    int exc_code_tab[9] = '{1, 0, 2, 3, 11, 6, 4, 7, 5};
    bit exc_tval_tab[9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
    // Interrupts in priority order: ext, soft, timer
    int irq_bit_tab[3]  = '{2, 0, 1};
    int irq_code_tab[3] = '{11, 3, 7};

    always #5 clk = ~clk;

    prv_trap_sequencer #(.RV_XLEN(32)) dut (
        .CLK         (clk),
        .RST         (rst),
        .exc_vec     (exc_vec),
        .ret         (ret),
        .pipe_clear  (pipe_clear),
        .epc         (epc),
        .badaddr     (badaddr),
        .irq_vec     (irq_vec),
        .mstatus_mie (mstatus_mie),
        .mie_en      (mie_en),
        .mtvec       (mtvec),
        .mepc_r      (mepc_r),
        .insert_pc   (insert_pc),
        .priv_pc     (priv_pc),
        .intr        (intr),
        .trap_we     (trap_we),
        .mret_we     (mret_we),
        .mepc_w      (mepc_w),
        .mcause_w    (mcause_w),
        .mtval_w     (mtval_w),
        .busy        (busy)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string name);
        chk({name, ".busy"},      {31'd0, busy},      32'd0);
        chk({name, ".insert_pc"}, {31'd0, insert_pc}, 32'd0);
        chk({name, ".trap_we"},   {31'd0, trap_we},   32'd0);
        chk({name, ".mret_we"},   {31'd0, mret_we},   32'd0);
        chk({name, ".intr"},      {31'd0, intr},      32'd0);
        chk({name, ".priv_pc"},   priv_pc,            32'd0);
        chk({name, ".mepc_w"},    mepc_w,             32'd0);
        chk({name, ".mcause_w"},  mcause_w,           32'd0);
        chk({name, ".mtval_w"},   mtval_w,            32'd0);
    endtask

    task automatic clear_events();
        exc_vec     = '0;
        irq_vec     = '0;
        ret         = 1'b0;
        mie_en      = '0;
        mstatus_mie = 1'b0;
        pipe_clear  = 1'b0;
    endtask

    task automatic scramble_events();
        exc_vec     = 9'($urandom);
        irq_vec     = 3'($urandom);
        mie_en      = 3'($urandom);
        mstatus_mie = 1'($urandom);
        ret         = 1'($urandom);
        epc         = $urandom;
        badaddr     = $urandom;
    endtask

    // One full transaction from IDLE back to IDLE, checked cycle by cycle
    task automatic do_txn(input string tag, input logic [8:0] exc, input logic [2:0] irq,
                          input logic [2:0] en, input logic mie, input logic rt,
                          input logic [31:0] pc, input logic [31:0] ba,
                          input logic [31:0] tv, input logic [31:0] mr, input int waitc);
        int          kind;
        bit          is_int;
        int          code;
        logic [31:0] e_tval;
        logic [31:0] e_pc;
        logic [31:0] e_cause;
        logic [2:0]  pend;

        kind = 0; is_int = 0; code = 0; e_tval = 0; e_pc = 0; e_cause = 0;
        pend = irq & en;
        if (exc != 0) begin
            kind = 1;
            for (int i = 8; i >= 0; i--) begin
                if (exc[i]) begin
                    code   = exc_code_tab[i];
                    e_tval = exc_tval_tab[i] ? ba : 32'd0;
                end
            end
        end else if (mie && pend != 0) begin
            kind = 1;
            is_int = 1;
            for (int i = 2; i >= 0; i--) begin
                if (pend[irq_bit_tab[i]]) code = irq_code_tab[i];
            end
        end else if (rt) begin
            kind = 2;
        end
        if (kind == 1) begin
            e_cause = (is_int ? 32'h8000_0000 : 32'd0) + 32'(code);
            e_pc = tv & 32'hFFFF_FFFC;
`ifdef PRV_VECTORED_INT_EN
            if (is_int && tv[1:0] == 2'b01) e_pc = e_pc + 32'(4 * code);
`endif
        end else if (kind == 2) begin
            e_pc = mr;
        end

        @(negedge clk);
        exc_vec = exc; irq_vec = irq; mie_en = en; mstatus_mie = mie; ret = rt;
        epc = pc; badaddr = ba; mtvec = tv; mepc_r = mr; pipe_clear = 1'b0;
        @(negedge clk);
        if (kind == 0) begin
            chk_quiet({tag, ".none"});
            clear_events();
            $display("TXN %s kind=none", tag);
            return;
        end
        chk({tag, ".wait.busy"},   {31'd0, busy},      32'd1);
        chk({tag, ".wait.insert"}, {31'd0, insert_pc}, 32'd0);
        chk({tag, ".wait.intr"},   {31'd0, intr},      {31'd0, is_int});
        scramble_events();
        for (int w = 0; w < waitc; w++) begin
            @(negedge clk);
            chk({tag, ".hold.busy"},   {31'd0, busy},      32'd1);
            chk({tag, ".hold.insert"}, {31'd0, insert_pc}, 32'd0);
            chk({tag, ".hold.strobe"}, {30'd0, trap_we, mret_we}, 32'd0);
            chk({tag, ".hold.intr"},   {31'd0, intr},      {31'd0, is_int});
            scramble_events();
        end
        pipe_clear = 1'b1;
        @(negedge clk);
        chk({tag, ".go.insert"},  {31'd0, insert_pc}, 32'd1);
        chk({tag, ".go.trap_we"}, {31'd0, trap_we},   {31'd0, kind == 1});
        chk({tag, ".go.mret_we"}, {31'd0, mret_we},   {31'd0, kind == 2});
        chk({tag, ".go.priv_pc"}, priv_pc,            e_pc);
        chk({tag, ".go.intr"},    {31'd0, intr},      {31'd0, is_int});
        chk({tag, ".go.mcause"},  mcause_w,           e_cause);
        chk({tag, ".go.mepc"},    mepc_w,             (kind == 1) ? pc : 32'd0);
        chk({tag, ".go.mtval"},   mtval_w,            e_tval);
        clear_events();
        @(negedge clk);
        chk_quiet({tag, ".idle"});
        $display("TXN %s kind=%0d cause=%h priv_pc=%h wait=%0d", tag, kind, e_cause, e_pc, waitc);
    endtask

    initial begin
        rst = 1'b1;
        clear_events();
        epc = '0; badaddr = '0; mtvec = '0; mepc_r = '0;
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        rst = 1'b0;
        $display("TXN reset");

        do_txn("illegal",       9'h004, 3'b000, 3'b000, 1'b0, 1'b0, 32'h100, 32'hDEAD, 32'h4000, 32'h0, 0);
        do_txn("malL_faultI",   9'h041, 3'b000, 3'b000, 1'b0, 1'b0, 32'h200, 32'h2003, 32'h4000, 32'h0, 1);
        do_txn("irq_ext_vec",   9'h000, 3'b111, 3'b110, 1'b1, 1'b0, 32'h300, 32'h55,   32'h8001, 32'h0, 0);
        do_txn("mret_wait5",    9'h000, 3'b000, 3'b000, 1'b0, 1'b1, 32'h0,   32'h0,    32'h8000, 32'h440, 5);
        do_txn("timer_drop",    9'h000, 3'b010, 3'b010, 1'b1, 1'b0, 32'h500, 32'h77,   32'h9000, 32'h0, 2);
        do_txn("ret_vs_faultS", 9'h080, 3'b000, 3'b000, 1'b0, 1'b1, 32'h600, 32'hABC,  32'hA000, 32'h990, 1);
        do_txn("irq_masked",    9'h000, 3'b111, 3'b111, 1'b0, 1'b0, 32'h700, 32'h0,    32'hB000, 32'h0, 0);
        do_txn("env_m",         9'h010, 3'b111, 3'b111, 1'b1, 1'b1, 32'h800, 32'h123,  32'hC001, 32'h0, 0);

        // Reset while waiting for the drain aborts without any strobe
        @(negedge clk);
        exc_vec = 9'h004; epc = 32'h900;
        @(negedge clk);
        chk("rst_abort.busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1; pipe_clear = 1'b1; exc_vec = '0;
        @(negedge clk);
        chk_quiet("rst_abort.after");
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("rst_abort.no_go");
        pipe_clear = 1'b0;
        $display("TXN rst_abort");

        for (int n = 0; n < 60; n++) begin
            logic [8:0] r_exc;
            logic [2:0] r_irq, r_en;
            logic       r_mie, r_ret;
            int         mode;
            mode  = int'($urandom_range(0, 3));
            r_exc = 9'($urandom) & 9'($urandom);
            r_irq = 3'($urandom);
            r_en  = 3'($urandom);
            r_mie = 1'($urandom);
            r_ret = 1'($urandom);
            if (mode == 1) r_exc = '0;
            if (mode == 2) begin r_exc = '0; r_mie = 1'b0; r_ret = 1'b1; end
            do_txn($sformatf("rand%0d", n), r_exc, r_irq, r_en, r_mie, r_ret,
                   $urandom, $urandom, $urandom, $urandom, int'($urandom_range(0, 4)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
